// File: rtl/decode_cycle.sv
// decode_cycle: ID stage of a 5-stage RV32I pipeline.
// This stage decodes the IF/ID instruction into controls, an immediate and
// register operands. It holds the register file, which WB writes, and it
// registers every result into the ID/EX pipeline register.
module decode_cycle #(
    parameter int RF_DEPTH = 32,
    parameter int XLEN     = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     INSTR_D_i,
    input  logic [XLEN-1:0] PC_D_i,
    input  logic [XLEN-1:0] PC_plus4_D_i,
    input  logic            CLR_H_i,
    input  logic            REG_WRITE_W_i,
    input  logic [4:0]      RD_W_i,
    input  logic [XLEN-1:0] RESULT_W_i,
    output logic [4:0]      RS1_D_o,
    output logic [4:0]      RS2_D_o,
    output logic [XLEN-1:0] RD1_E_o,
    output logic [XLEN-1:0] RD2_E_o,
    output logic [XLEN-1:0] IMM_E_o,
    output logic [XLEN-1:0] PC_E_o,
    output logic [XLEN-1:0] PC_plus4_E_o,
    output logic [4:0]      RS1_E_o,
    output logic [4:0]      RS2_E_o,
    output logic [4:0]      RD_E_o,
    output logic [2:0]      FUNCT3_E_o,
    output logic [3:0]      ALU_CTRL_E_o,
    output logic [1:0]      ALU_SRCA_E_o,
    output logic            ALU_SRCB_E_o,
    output logic [1:0]      RESULT_SRC_E_o,
    output logic            REG_WRITE_E_o,
    output logic            MEM_WRITE_E_o,
    output logic            BRANCH_E_o,
    output logic            JUMP_E_o,
    output logic            JALR_E_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // funct7[5] selects SUB only for register-register ops; ADDI never subtracts.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b,
                                          input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg && f7b) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic [2:0] funct3;
    logic       funct7b;
    logic       wb_en;

    assign opcode  = INSTR_D_i[6:0];
    assign rd_f    = INSTR_D_i[11:7];
    assign funct3  = INSTR_D_i[14:12];
    assign rs1_f   = INSTR_D_i[19:15];
    assign rs2_f   = INSTR_D_i[24:20];
    assign funct7b = INSTR_D_i[30];
    assign wb_en   = REG_WRITE_W_i && (RD_W_i != 5'd0);

    assign RS1_D_o = rs1_f;
    assign RS2_D_o = rs2_f;

    logic [XLEN-1:0] rf_q [RF_DEPTH];

    logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
    logic [4:0]      rd_d;
    logic [3:0]      alu_ctrl_d;
    logic [1:0]      srca_d, rsrc_d;
    logic            srcb_d, regw_d, memw_d, br_d, jump_d, jalr_d;

    logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc4_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [2:0]      funct3_q;
    logic [3:0]      alu_ctrl_q;
    logic [1:0]      srca_q, rsrc_q;
    logic            srcb_q, regw_q, memw_q, br_q, jump_q, jalr_q;

    // Register file read with x0 forced to zero and a WB bypass for same-cycle writes.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (rs1_f != 5'd0)
            rd1_d = (wb_en && RD_W_i == rs1_f) ? RESULT_W_i : rf_q[rs1_f];
        if (rs2_f != 5'd0)
            rd2_d = (wb_en && RD_W_i == rs2_f) ? RESULT_W_i : rf_q[rs2_f];
    end

    // Decode: the immediate format and controls follow the opcode; an unknown opcode becomes a NOP.
    always_comb begin
        alu_ctrl_d = ALU_ADD;
        srca_d     = 2'b00;
        srcb_d     = 1'b0;
        rsrc_d     = 2'b00;
        regw_d     = 1'b0;
        memw_d     = 1'b0;
        br_d       = 1'b0;
        jump_d     = 1'b0;
        jalr_d     = 1'b0;
        rd_d       = rd_f;
        imm_d      = {{20{INSTR_D_i[31]}}, INSTR_D_i[31:20]};
        case (opcode)
            OP_R: begin
                alu_ctrl_d = alu_op(funct3, funct7b, 1'b1);
                regw_d     = 1'b1;
            end
            OP_IMM: begin
                alu_ctrl_d = alu_op(funct3, funct7b, 1'b0);
                srcb_d     = 1'b1;
                regw_d     = 1'b1;
            end
            OP_LOAD: begin
                srcb_d = 1'b1;
                rsrc_d = 2'b01;
                regw_d = 1'b1;
            end
            OP_STORE: begin
                srcb_d = 1'b1;
                memw_d = 1'b1;
                rd_d   = 5'd0;
                imm_d  = {{20{INSTR_D_i[31]}}, INSTR_D_i[31:25], INSTR_D_i[11:7]};
            end
            OP_BRANCH: begin
                alu_ctrl_d = ALU_SUB;
                br_d       = 1'b1;
                rd_d       = 5'd0;
                imm_d      = {{19{INSTR_D_i[31]}}, INSTR_D_i[31], INSTR_D_i[7],
                              INSTR_D_i[30:25], INSTR_D_i[11:8], 1'b0};
            end
            OP_JAL: begin
                jump_d = 1'b1;
                rsrc_d = 2'b10;
                regw_d = 1'b1;
                imm_d  = {{11{INSTR_D_i[31]}}, INSTR_D_i[31], INSTR_D_i[19:12],
                          INSTR_D_i[20], INSTR_D_i[30:21], 1'b0};
            end
            OP_JALR: begin
                jump_d = 1'b1;
                jalr_d = 1'b1;
                srcb_d = 1'b1;
                rsrc_d = 2'b10;
                regw_d = 1'b1;
            end
            OP_LUI: begin
                srca_d = 2'b10;
                srcb_d = 1'b1;
                regw_d = 1'b1;
                imm_d  = {INSTR_D_i[31:12], 12'h000};
            end
            OP_AUIPC: begin
                srca_d = 2'b01;
                srcb_d = 1'b1;
                regw_d = 1'b1;
                imm_d  = {INSTR_D_i[31:12], 12'h000};
            end
            default: ;
        endcase
    end

    // Register file write from WB; x0 is never written.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < RF_DEPTH; i++)
                rf_q[i] <= '0;
        end else if (wb_en) begin
            rf_q[RD_W_i] <= RESULT_W_i;
        end
    end

    // ID/EX register: a flush loads an all-zero bubble and takes priority over capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i || CLR_H_i) begin
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            pc4_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            alu_ctrl_q <= '0;
            srca_q     <= '0;
            srcb_q     <= 1'b0;
            rsrc_q     <= '0;
            regw_q     <= 1'b0;
            memw_q     <= 1'b0;
            br_q       <= 1'b0;
            jump_q     <= 1'b0;
            jalr_q     <= 1'b0;
        end else begin
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            pc_q       <= PC_D_i;
            pc4_q      <= PC_plus4_D_i;
            rs1_q      <= rs1_f;
            rs2_q      <= rs2_f;
            rd_q       <= rd_d;
            funct3_q   <= funct3;
            alu_ctrl_q <= alu_ctrl_d;
            srca_q     <= srca_d;
            srcb_q     <= srcb_d;
            rsrc_q     <= rsrc_d;
            regw_q     <= regw_d;
            memw_q     <= memw_d;
            br_q       <= br_d;
            jump_q     <= jump_d;
            jalr_q     <= jalr_d;
        end
    end

    assign RD1_E_o        = rd1_q;
    assign RD2_E_o        = rd2_q;
    assign IMM_E_o        = imm_q;
    assign PC_E_o         = pc_q;
    assign PC_plus4_E_o   = pc4_q;
    assign RS1_E_o        = rs1_q;
    assign RS2_E_o        = rs2_q;
    assign RD_E_o         = rd_q;
    assign FUNCT3_E_o     = funct3_q;
    assign ALU_CTRL_E_o   = alu_ctrl_q;
    assign ALU_SRCA_E_o   = srca_q;
    assign ALU_SRCB_E_o   = srcb_q;
    assign RESULT_SRC_E_o = rsrc_q;
    assign REG_WRITE_E_o  = regw_q;
    assign MEM_WRITE_E_o  = memw_q;
    assign BRANCH_E_o     = br_q;
    assign JUMP_E_o       = jump_q;
    assign JALR_E_o       = jalr_q;

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed scenarios followed by randomized instruction
// streams. Random instructions are assembled from a chosen instruction class,
// and the expected controls come from that class rather than from decoding.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr, pc, pc4, result_w;
    logic        clr, we;
    logic [4:0]  rd_w;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
    logic [2:0]  f3_e;
    logic [3:0]  alu_e;
    logic [1:0]  srca_e, rsrc_e;
    logic        srcb_e, regw_e, memw_e, br_e, jump_e, jalr_e;

    int n_checks = 0;
    int n_errors = 0;

    decode_cycle dut (
        .clk_i(clk), .rst_i(rst),
        .INSTR_D_i(instr), .PC_D_i(pc), .PC_plus4_D_i(pc4), .CLR_H_i(clr),
        .REG_WRITE_W_i(we), .RD_W_i(rd_w), .RESULT_W_i(result_w),
        .RS1_D_o(rs1_d), .RS2_D_o(rs2_d),
        .RD1_E_o(rd1_e), .RD2_E_o(rd2_e), .IMM_E_o(imm_e),
        .PC_E_o(pc_e), .PC_plus4_E_o(pc4_e),
        .RS1_E_o(rs1_e), .RS2_E_o(rs2_e), .RD_E_o(rd_e), .FUNCT3_E_o(f3_e),
        .ALU_CTRL_E_o(alu_e), .ALU_SRCA_E_o(srca_e), .ALU_SRCB_E_o(srcb_e),
        .RESULT_SRC_E_o(rsrc_e), .REG_WRITE_E_o(regw_e), .MEM_WRITE_E_o(memw_e),
        .BRANCH_E_o(br_e), .JUMP_E_o(jump_e), .JALR_E_o(jalr_e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic c, input logic w,
                         input logic [4:0] r, input logic [31:0] v);
        instr = i; clr = c; we = w; rd_w = r; result_w = v;
    endtask

    // Reference model state
    logic [31:0] rf_m [32];
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [2:0]  e_f3;
    logic [3:0]  e_alu;
    logic [1:0]  e_srca, e_rsrc;
    logic        e_srcb, e_regw, e_memw, e_br, e_jump, e_jalr, e_imm_chk;

    // ALU code -> (funct3, funct7[5]) encoding table for R-type instructions
    logic [2:0] r_f3 [10] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5, 3'd2, 3'd3};
    logic       r_f7 [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (we && rd_w != 5'd0 && rd_w == idx) return result_w;
        return rf_m[idx];
    endfunction

    function automatic bit known_op(input logic [6:0] op);
        case (op)
            7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic gen(output logic [31:0] ins);
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [19:0] u20;
        logic [6:0]  op;
        int          cls, k;
        r = $urandom; rd = r[4:0]; rs1 = r[9:5]; rs2 = r[14:10]; f3 = r[17:15];
        r = $urandom; i12 = r[11:0]; u20 = r[31:12];
        e_alu = 4'd0; e_srca = 2'd0; e_srcb = 1'b0; e_rsrc = 2'd0; e_regw = 1'b0;
        e_memw = 1'b0; e_br = 1'b0; e_jump = 1'b0; e_jalr = 1'b0; e_imm_chk = 1'b1;
        e_imm = {{20{i12[11]}}, i12};
        cls = $urandom_range(0, 11);
        case (cls)
            0: begin
                k = $urandom_range(0, 9);
                ins = {1'b0, r_f7[k], 5'd0, rs2, rs1, r_f3[k], rd, 7'h33};
                e_alu = 4'(k); e_regw = 1'b1; e_imm_chk = 1'b0;
            end
            1: begin
                // every ALU code except SUB has an immediate form
                k = $urandom_range(0, 8);
                if (k >= 1) k++;
                if (r_f3[k] == 3'd1 || r_f3[k] == 3'd5)
                    i12 = {1'b0, r_f7[k], 5'd0, i12[4:0]};
                ins = {i12, rs1, r_f3[k], rd, 7'h13};
                e_imm = {{20{i12[11]}}, i12};
                e_alu = 4'(k); e_srcb = 1'b1; e_regw = 1'b1;
            end
            2: begin
                ins = {i12, rs1, f3, rd, 7'h03};
                e_srcb = 1'b1; e_rsrc = 2'b01; e_regw = 1'b1;
            end
            3: begin
                ins = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
                e_srcb = 1'b1; e_memw = 1'b1;
            end
            4: begin
                b13 = {r[12:1], 1'b0};
                ins = {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], 7'h63};
                e_imm = {{19{b13[12]}}, b13};
                e_alu = 4'd1; e_br = 1'b1;
            end
            5: begin
                j21 = {r[20:1], 1'b0};
                ins = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6f};
                e_imm = {{11{j21[20]}}, j21};
                e_jump = 1'b1; e_rsrc = 2'b10; e_regw = 1'b1;
            end
            6: begin
                ins = {i12, rs1, 3'd0, rd, 7'h67};
                e_jump = 1'b1; e_jalr = 1'b1; e_srcb = 1'b1; e_rsrc = 2'b10; e_regw = 1'b1;
            end
            7, 8: begin
                ins = {u20, rd, (cls == 7) ? 7'h37 : 7'h17};
                e_imm = {u20, 12'h0};
                e_srca = (cls == 7) ? 2'b10 : 2'b01; e_srcb = 1'b1; e_regw = 1'b1;
            end
            9, 10: begin
                do begin
                    r = $urandom; op = r[6:0];
                end while (known_op(op));
                r = $urandom;
                ins = {r[31:7], op};
                e_imm_chk = 1'b0;
            end
            default: begin
                ins = 32'h0;
                e_imm = 32'h0;
            end
        endcase
        e_rs1 = ins[19:15]; e_rs2 = ins[24:20]; e_f3 = ins[14:12];
        e_rd  = (cls == 3 || cls == 4) ? 5'd0 : ins[11:7];
    endtask

    task automatic check_ex();
        chk("rd1", rd1_e, e_rd1);
        chk("rd2", rd2_e, e_rd2);
        if (e_imm_chk) chk("imm", imm_e, e_imm);
        chk("pc", pc_e, e_pc);
        chk("pc4", pc4_e, e_pc4);
        chk("rs1_e", rs1_e, e_rs1);
        chk("rs2_e", rs2_e, e_rs2);
        chk("rd_e", rd_e, e_rd);
        chk("funct3", f3_e, e_f3);
        chk("alu", alu_e, e_alu);
        chk("srca", srca_e, e_srca);
        chk("srcb", srcb_e, e_srcb);
        chk("rsrc", rsrc_e, e_rsrc);
        chk("regw", regw_e, e_regw);
        chk("memw", memw_e, e_memw);
        chk("branch", br_e, e_br);
        chk("jump", jump_e, e_jump);
        chk("jalr", jalr_e, e_jalr);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] r;
        bit have_exp;

        drive(32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        pc = 32'h100; pc4 = 32'h104;
        foreach (rf_m[i]) rf_m[i] = 32'h0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_imm", imm_e, 32'h0);
        chk("rst_regw", regw_e, 1'b0);
        chk("rst_pc", pc_e, 32'h0);
        chk("rst_rd1", rd1_e, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ADDI x1,x0,5
        drive(32'h00500093, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("addi_imm", imm_e, 32'h5);
        chk("addi_rd", rd_e, 32'd1);
        chk("addi_alu", alu_e, 4'b0000);
        chk("addi_srcb", srcb_e, 1'b1);
        chk("addi_regw", regw_e, 1'b1);
        chk("addi_rd1", rd1_e, 32'h0);
        chk("addi_pc", pc_e, 32'h100);
        chk("addi_pc4", pc4_e, 32'h104);

        // WB x1=7, x2=3, then SUB x3,x1,x2
        drive(32'h0, 1'b0, 1'b1, 5'd1, 32'd7);
        @(negedge clk);
        chk("nop_regw", regw_e, 1'b0);
        drive(32'h0, 1'b0, 1'b1, 5'd2, 32'd3);
        @(negedge clk);
        drive(32'h402081B3, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("rs1_d", rs1_d, 5'd1);
        chk("rs2_d", rs2_d, 5'd2);
        @(negedge clk);
        chk("sub_rd1", rd1_e, 32'd7);
        chk("sub_rd2", rd2_e, 32'd3);
        chk("sub_alu", alu_e, 4'b0001);
        chk("sub_rd", rd_e, 5'd3);

        // BEQ x1,x2,-8
        drive(32'hFE208CE3, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("beq_imm", imm_e, 32'hFFFFFFF8);
        chk("beq_branch", br_e, 1'b1);
        chk("beq_regw", regw_e, 1'b0);
        chk("beq_rd", rd_e, 5'd0);
        chk("beq_f3", f3_e, 3'b000);
        chk("beq_alu", alu_e, 4'b0001);

        // Same-cycle bypass: WB x5 while ADD x6,x5,x0 reads it
        drive(32'h00028333, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("bypass_rd1", rd1_e, 32'hDEADBEEF);
        // A write to x0 must neither bypass nor stick
        drive(32'h00000333, 1'b0, 1'b1, 5'd0, 32'h1234);
        @(negedge clk);
        chk("x0_bypass", rd1_e, 32'h0);
        drive(32'h00000333, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("x0_read", rd1_e, 32'h0);

        // LUI x5,0x12345 with flush, then without
        drive(32'h123452B7, 1'b1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("flush_imm", imm_e, 32'h0);
        chk("flush_srca", srca_e, 2'b00);
        chk("flush_regw", regw_e, 1'b0);
        chk("flush_rd", rd_e, 5'd0);
        chk("flush_pc", pc_e, 32'h0);
        chk("flush_srcb", srcb_e, 1'b0);
        drive(32'h123452B7, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("lui_imm", imm_e, 32'h12345000);
        chk("lui_srca", srca_e, 2'b10);
        chk("lui_srcb", srcb_e, 1'b1);
        chk("lui_regw", regw_e, 1'b1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_imm", imm_e, 32'h0);
        chk("arst_srca", srca_e, 2'b00);
        chk("arst_regw", regw_e, 1'b0);
        chk("arst_pc", pc_e, 32'h0);
        foreach (rf_m[i]) rf_m[i] = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        drive(32'h00008113, 1'b0, 1'b0, 5'd0, 32'h0);   // ADDI x2,x1,0
        @(negedge clk);
        chk("arst_x1", rd1_e, 32'h0);
        chk("arst_rd", rd_e, 5'd2);

        // Randomized stream against the reference model
        have_exp = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (have_exp) check_ex();
            gen(ins);
            r = $urandom;
            pc = r & 32'hFFFF_FFFC;
            pc4 = pc + 32'd4;
            drive(ins, ($urandom_range(0, 9) == 0), r[0], 5'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) rd_w = ins[19:15];
            #1;
            chk("rs1_d", rs1_d, ins[19:15]);
            chk("rs2_d", rs2_d, ins[24:20]);
            e_rd1 = model_read(ins[19:15]);
            e_rd2 = model_read(ins[24:20]);
            e_pc = pc; e_pc4 = pc4;
            if (clr) begin
                e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_pc = 0; e_pc4 = 0;
                e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_f3 = 0; e_alu = 0; e_srca = 0;
                e_srcb = 0; e_rsrc = 0; e_regw = 0; e_memw = 0; e_br = 0;
                e_jump = 0; e_jalr = 0; e_imm_chk = 1'b1;
            end
            if (we && rd_w != 5'd0) rf_m[rd_w] = result_w;
            have_exp = 1'b1;
            @(negedge clk);
        end
        check_ex();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
ID stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage. It consumes the IF/ID register outputs (INSTR_D, PC_D, PC_plus4_D) and decodes the instruction into controls, an immediate and register operands. It holds the 32x32 register file, written from WB, and registers everything into the ID/EX pipeline register. The hazard unit can flush that register to insert a bubble.

Parameters:
RF_DEPTH, 32, number of architectural registers (x0 hardwired to zero)
XLEN, 32, datapath width

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  asynchronous active-low reset
INSTR_D_i  in  32  instruction from IF/ID
PC_D_i  in  32  PC of that instruction
PC_plus4_D_i  in  32  PC+4 of that instruction
CLR_H_i  in  1  hazard flush of ID/EX (synchronous, active-high)
REG_WRITE_W_i  in  1  WB register-write enable
RD_W_i  in  5  WB destination register
RESULT_W_i  in  32  WB write data
RS1_D_o, RS2_D_o  out  5 each  combinational source indices (for hazard unit)
RD1_E_o, RD2_E_o  out  32 each  registered operand values
IMM_E_o  out  32  registered sign-extended immediate
PC_E_o, PC_plus4_E_o  out  32 each  registered PC and PC+4
RS1_E_o, RS2_E_o, RD_E_o  out  5 each  registered register indices
FUNCT3_E_o  out  3  registered funct3 (branch condition / load-store size)
ALU_CTRL_E_o  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
ALU_SRCA_E_o  out  2  00 RD1, 01 PC, 10 zero
ALU_SRCB_E_o  out  1  0 RD2, 1 IMM
RESULT_SRC_E_o  out  2  00 ALU, 01 memory, 10 PC+4
REG_WRITE_E_o, MEM_WRITE_E_o, BRANCH_E_o, JUMP_E_o, JALR_E_o  out  1 each  registered controls

Behaviour:
- Reset (rst_i low, asynchronous): all ID/EX outputs 0; all 32 RF entries 0.
- Decode is combinational from INSTR_D_i. The ID/EX register captures the decode result at each posedge: latency is 1 cycle.
- Flush: CLR_H_i high at posedge loads every ID/EX output with 0, which is a NOP bubble. CLR_H_i has priority over capture. The RF write in the same cycle still occurs.
- RF write: at posedge when REG_WRITE_W_i=1 and RD_W_i!=0. Writes to x0 are ignored.
- RF read: combinational. x0 reads as 0.
- WB bypass: if REG_WRITE_W_i=1, RD_W_i!=0 and RD_W_i==rs, the read returns RESULT_W_i. This covers a same-cycle write/read.
- Immediates:
  - I: {20{i31}, i[31:20]}
  - S: {20{i31}, i[31:25], i[11:7]}
  - B: {19{i31}, i31, i7, i[30:25], i[11:8], 0}
  - U: {i[31:12], 12'h0}
  - J: {11{i31}, i31, i[19:12], i20, i[30:21], 0}
- Opcodes:
  - R (0110011): ALU_CTRL from funct3 and funct7[5]; REG_WRITE=1.
  - I-ALU (0010011): SRCB=1, REG_WRITE=1. funct7[5] is used only for SRAI; ADDI never maps to SUB.
  - LOAD (0000011): ADD, SRCB=1, RESULT_SRC=01, REG_WRITE=1.
  - STORE (0100011): ADD, SRCB=1, MEM_WRITE=1.
  - BRANCH (1100011): SUB, BRANCH=1.
  - JAL (1101111): JUMP=1, RESULT_SRC=10, REG_WRITE=1.
  - JALR (1100111): JUMP=1, JALR=1, ADD, SRCB=1, RESULT_SRC=10, REG_WRITE=1.
  - LUI (0110111): SRCA=10, SRCB=1, ADD, REG_WRITE=1.
  - AUIPC (0010111): SRCA=01, SRCB=1, ADD, REG_WRITE=1.
- Unknown opcode, or INSTR_D_i=0 (IF/ID flushed): all controls 0 (NOP). Indices and immediate are still captured.
- RD_E_o is forced to 0 for STORE and BRANCH so the hazard unit sees no false destination.
- Reset deasserting mid-stream: the first posedge after deassertion captures normally.

Test Plan:
1. Reset, then release; INSTR_D_i=0x00500093 (ADDI x1,x0,5) → next cycle IMM_E=0x5, RD_E=1, ALU_CTRL=0000, SRCB=1, REG_WRITE=1, RD1_E=0.
2. WB writes x1=7 and x2=3, then INSTR=0x402081B3 (SUB x3,x1,x2) → RD1_E=7, RD2_E=3, ALU_CTRL=0001, RD_E=3.
3. INSTR=0xFE208CE3 (BEQ x1,x2,-8) → IMM_E=0xFFFFFFF8, BRANCH=1, REG_WRITE=0, RD_E=0, FUNCT3_E=000.
4. Same cycle: WB writes x5=0xDEADBEEF and INSTR=ADD x6,x5,x0 → RD1_E=0xDEADBEEF via bypass. A WB write to x0 → later read of x0 returns 0.
5. INSTR=0x123452B7 (LUI x5,0x12345) with CLR_H_i=1 → all ID/EX outputs 0. Repeat with CLR_H_i=0 → IMM_E=0x12345000, SRCA=10.
6. Assert rst_i low asynchronously mid-cycle → outputs 0 immediately, and a subsequent read of x1 returns 0.
